alu: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_if.sv | 25 ++
 rtl/alu_addsub.sv | 30 +++
 rtl/alu.sv | 65 ++++++
 tb/tb_alu.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU.
// Imported by the adder, the bus interface, the top and the bench.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_ADDSUB = 2'b00,
    OP_ANDB   = 2'b01,
    OP_XOR    = 2'b10,
    OP_SHIFT  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_Z = 2'b00,
    BR_N = 2'b01,
    BR_V = 2'b10,
    BR_C = 2'b11
  } br_sel_e;

endpackage

// File: rtl/alu_if.sv
// Operand/control bundle into the ALU and its registered result.
// The datapath drives the master side; the ALU owns the slave side.
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  alu_op_e           alu_op;
  logic              sub;
  logic              branch;
  br_sel_e           branch_sel;
  logic              shift_left;
  logic [DATA_W-1:0] out_val;

  modport master (
    output in1, in2, alu_op, sub, branch, branch_sel, shift_left,
    input  out_val
  );

  modport slave (
    input  in1, in2, alu_op, sub, branch, branch_sel, shift_left,
    output out_val
  );

endinterface

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor producing the sum and the Z/N/V/C flags.
// For subtract, the carry output is set when no borrow occurred.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] r,
  output logic              z,
  output logic              n,
  output logic              v,
  output logic              c
);

  logic [DATA_W-1:0] bx;
  logic [DATA_W:0]   sum;

  // Subtract is A + ~B + 1; the extra bit of the sum is the carry.
  always_comb begin
    bx  = b ^ {DATA_W{sub}};
    sum = {1'b0, a} + {1'b0, bx} + {{DATA_W{1'b0}}, sub};
    r   = sum[DATA_W-1:0];
    c   = sum[DATA_W];
    z   = (r == '0);
    n   = r[DATA_W-1];
    v   = (a[DATA_W-1] == bx[DATA_W-1]) & (r[DATA_W-1] != a[DATA_W-1]);
  end

endmodule

// File: rtl/alu.sv
// Eight-bit execute-stage ALU: operation mux, branch flag mux and a
// single result register giving one cycle of latency.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [DATA_W-1:0] sum_r;
  logic              flag_z;
  logic              flag_n;
  logic              flag_v;
  logic              flag_c;
  logic              flag;
  logic [DATA_W-1:0] op_result;
  logic [DATA_W-1:0] next_val;

  alu_addsub u_addsub (
    .a   (bus.in1),
    .b   (bus.in2),
    .sub (bus.sub),
    .r   (sum_r),
    .z   (flag_z),
    .n   (flag_n),
    .v   (flag_v),
    .c   (flag_c)
  );

  // Shift amounts of DATA_W or more already yield zero with SV shift
  // semantics, so the full in2 byte is used directly as the amount.
  always_comb begin
    op_result = '0;
    unique case (bus.alu_op)
      OP_ADDSUB: op_result = sum_r;
      OP_ANDB:   op_result = bus.in2[0] ? bus.in1 : '0;
      OP_XOR:    op_result = bus.in1 ^ bus.in2;
      OP_SHIFT:  op_result = bus.shift_left ? (bus.in1 << bus.in2)
                                            : (bus.in1 >> bus.in2);
      default:   op_result = '0;
    endcase
  end

  always_comb begin
    flag = 1'b0;
    unique case (bus.branch_sel)
      BR_Z:    flag = flag_z;
      BR_N:    flag = flag_n;
      BR_V:    flag = flag_v;
      BR_C:    flag = flag_c;
      default: flag = 1'b0;
    endcase
    next_val = bus.branch ? {{(DATA_W-1){1'b0}}, flag} : op_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_val <= '0;
    end else begin
      bus.out_val <= next_val;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for the ALU: expected results are queued when inputs
// are driven and popped when the registered output is sampled.
module tb_alu;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic drive(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                       input logic sb, input logic br, input br_sel_e bs,
                       input logic sl);
    bus.alu_op     = op;
    bus.in1        = a;
    bus.in2        = b;
    bus.sub        = sb;
    bus.branch     = br;
    bus.branch_sel = bs;
    bus.shift_left = sl;
  endtask

  // Inputs change on the falling edge so they are stable for the next rise.
  task automatic apply_stimulus(input alu_op_e op, input logic [7:0] a,
                                input logic [7:0] b, input logic sb,
                                input logic br, input br_sel_e bs,
                                input logic sl, input logic [7:0] expected);
    @(negedge clk);
    drive(op, a, b, sb, br, bs, sl);
    exp_q.push_back(expected);
  endtask

  task automatic check_output(input string tag);
    logic [7:0] e;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s: observed %0d but no expectation queued", tag, bus.out_val);
    end else begin
      e = exp_q.pop_front();
      assert (bus.out_val === e)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, bus.out_val, e);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [7:0] expected);
    checks++;
    assert (bus.out_val === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, bus.out_val, expected);
    end
  endtask

  task automatic step(input string tag, input alu_op_e op, input logic [7:0] a,
                      input logic [7:0] b, input logic sb, input logic br,
                      input br_sel_e bs, input logic sl, input logic [7:0] expected);
    apply_stimulus(op, a, b, sb, br, bs, sl, expected);
    check_output(tag);
  endtask

  initial begin
    $display("[TB] starting ALU bench");
    drive(OP_ADDSUB, 8'd10, 8'd15, 1'b0, 1'b0, BR_Z, 1'b0);

    // Held in reset across an edge: the add must not load.
    #1;
    check_now("reset_async", 8'd0);
    @(posedge clk);
    #1;
    check_now("reset_held", 8'd0);

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(8'd25);
    check_output("reset_release_add");

    step("add",        OP_ADDSUB, 8'd10,  8'd15,  1'b0, 1'b0, BR_Z, 1'b0, 8'd25);
    step("sub",        OP_ADDSUB, 8'd20,  8'd5,   1'b1, 1'b0, BR_Z, 1'b0, 8'd15);
    step("add_wrap",   OP_ADDSUB, 8'd200, 8'd100, 1'b0, 1'b0, BR_Z, 1'b0, 8'd44);
    step("sub_small",  OP_ADDSUB, 8'd5,   8'd4,   1'b1, 1'b0, BR_Z, 1'b0, 8'd1);
    step("sub_under",  OP_ADDSUB, 8'd0,   8'd1,   1'b1, 1'b0, BR_Z, 1'b0, 8'hFF);

    step("andb_pass",  OP_ANDB,   8'hAA,  8'h01,  1'b0, 1'b0, BR_Z, 1'b0, 8'hAA);
    step("andb_gate",  OP_ANDB,   8'hAA,  8'hFE,  1'b0, 1'b0, BR_Z, 1'b0, 8'h00);
    step("xor",        OP_XOR,    8'hF0,  8'hAA,  1'b0, 1'b0, BR_Z, 1'b0, 8'h5A);

    step("shl",        OP_SHIFT,  8'd3,   8'd2,   1'b0, 1'b0, BR_Z, 1'b1, 8'd12);
    step("shr",        OP_SHIFT,  8'd12,  8'd2,   1'b0, 1'b0, BR_Z, 1'b0, 8'd3);
    step("shr7",       OP_SHIFT,  8'h80,  8'd7,   1'b0, 1'b0, BR_Z, 1'b0, 8'h01);
    step("shl8",       OP_SHIFT,  8'hFF,  8'd8,   1'b0, 1'b0, BR_Z, 1'b1, 8'h00);
    step("shr_big",    OP_SHIFT,  8'hFF,  8'd200, 1'b0, 1'b0, BR_Z, 1'b0, 8'h00);
    step("shl0",       OP_SHIFT,  8'h5C,  8'd0,   1'b0, 1'b0, BR_Z, 1'b1, 8'h5C);

    // Branch flags; alu_op is set to non-add values to show it is ignored.
    step("br_z_eq",    OP_SHIFT,  8'd5,   8'd5,   1'b1, 1'b1, BR_Z, 1'b1, 8'd1);
    step("br_z_ne",    OP_XOR,    8'd5,   8'd4,   1'b1, 1'b1, BR_Z, 1'b0, 8'd0);
    step("br_n",       OP_ANDB,   8'd10,  8'd20,  1'b1, 1'b1, BR_N, 1'b0, 8'd1);
    step("br_n_clr",   OP_ADDSUB, 8'd20,  8'd10,  1'b1, 1'b1, BR_N, 1'b0, 8'd0);
    step("br_v_set",   OP_SHIFT,  8'd127, 8'hFF,  1'b1, 1'b1, BR_V, 1'b0, 8'd1);
    step("br_v_clr",   OP_ADDSUB, 8'd127, 8'd1,   1'b1, 1'b1, BR_V, 1'b0, 8'd0);
    step("br_c_set",   OP_XOR,    8'd20,  8'd5,   1'b1, 1'b1, BR_C, 1'b0, 8'd1);
    step("br_c_clr",   OP_ADDSUB, 8'd5,   8'd20,  1'b1, 1'b1, BR_C, 1'b0, 8'd0);
    step("br_c_add",   OP_ADDSUB, 8'd200, 8'd100, 1'b0, 1'b1, BR_C, 1'b0, 8'd1);

    // Back-to-back across every operation, one new op per cycle.
    step("b2b_add",    OP_ADDSUB, 8'd1,   8'd2,   1'b0, 1'b0, BR_Z, 1'b0, 8'd3);
    step("b2b_andb",   OP_ANDB,   8'h3C,  8'h03,  1'b0, 1'b0, BR_Z, 1'b0, 8'h3C);
    step("b2b_xor",    OP_XOR,    8'h0F,  8'hFF,  1'b0, 1'b0, BR_Z, 1'b0, 8'hF0);
    step("b2b_shr",    OP_SHIFT,  8'hF0,  8'd4,   1'b0, 1'b0, BR_Z, 1'b0, 8'h0F);
    step("b2b_sub",    OP_ADDSUB, 8'd9,   8'd2,   1'b1, 1'b0, BR_Z, 1'b0, 8'd7);
    step("b2b_shl",    OP_SHIFT,  8'h81,  8'd1,   1'b0, 1'b0, BR_Z, 1'b1, 8'h02);

    // Mid-stream reset clears the output between edges and drops the op in flight.
    apply_stimulus(OP_XOR, 8'h55, 8'h0F, 1'b0, 1'b0, BR_Z, 1'b0, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("rst_mid_async", 8'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check_now("rst_mid_held", 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", OP_ADDSUB, 8'd100, 8'd28, 1'b0, 1'b0, BR_Z, 1'b0, 8'd128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
